// File: rtl/tx_hex_display_feeder.sv
// Captures each byte accepted by the UART transmitter and presents the last two
// bytes as four hex digits, with blanking, a frame counter, activity flash and stall flag.
module tx_hex_display_feeder #(
   parameter int FLASH_CYCLES = 5_000_000,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       tx_busy,
   input  logic       clear,
   output logic [3:0] nib0,
   output logic [3:0] nib1,
   output logic [3:0] nib2,
   output logic [3:0] nib3,
   output logic [3:0] blank,
   output logic [7:0] byte_cnt,
   output logic       activity,
   output logic       stall
);

   localparam int FW = (FLASH_CYCLES < 1) ? 1 : $clog2(FLASH_CYCLES + 1);
   localparam int TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);
   localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);
   localparam logic [TW-1:0] TO_LAST    = TW'(BUSY_TIMEOUT - 1);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WAIT_BUSY = 2'd1;
   localparam logic [1:0] S_SENDING   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [FW-1:0] flash_q, flash_d;
   logic          act_q, act_d;
   logic          stall_q, stall_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [3:0]    blank_q, blank_d;
   logic [15:0]   nib_q, nib_d;
   logic          accept, done, timeout;

   always_comb begin
      state_d  = state_q;
      to_cnt_d = to_cnt_q;
      accept   = 1'b0;
      done     = 1'b0;
      timeout  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tx_start && !tx_busy) begin
               accept   = 1'b1;
               state_d  = S_WAIT_BUSY;
               to_cnt_d = '0;
            end
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_SENDING;
            end else if (to_cnt_q == TO_LAST) begin
               timeout  = 1'b1;
               state_d  = S_IDLE;
               to_cnt_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_SENDING: begin
            if (!tx_busy) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Digits 0/1 load the new byte; digits 2/3 inherit whatever digits 0/1 held.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         logic [3:0] cap_nib;
         logic       cap_blank;
         if (gi < 2) begin : g_new
            assign cap_nib   = tx_data[gi*4 +: 4];
            assign cap_blank = 1'b0;
         end else begin : g_old
            assign cap_nib   = nib_q[(gi-2)*4 +: 4];
            assign cap_blank = blank_q[gi-2];
         end
         assign nib_d[gi*4 +: 4] = clear ? 4'h0 : (accept ? cap_nib : nib_q[gi*4 +: 4]);
         assign blank_d[gi]      = clear ? 1'b1 : (accept ? cap_blank : blank_q[gi]);
      end
   endgenerate

   always_comb begin
      cnt_d   = cnt_q;
      stall_d = stall_q;
      flash_d = flash_q;
      if (clear) begin
         cnt_d   = '0;
         stall_d = 1'b0;
         flash_d = '0;
      end else begin
         if (done)
            cnt_d = cnt_q + 8'd1;
         if (timeout)
            stall_d = 1'b1;
         if (accept)
            flash_d = FLASH_LOAD;
         else if (flash_q != '0)
            flash_d = flash_q - 1'b1;
      end
      act_d = (flash_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         to_cnt_q <= '0;
         flash_q  <= '0;
         act_q    <= 1'b0;
         stall_q  <= 1'b0;
         cnt_q    <= '0;
         blank_q  <= 4'b1111;
         nib_q    <= '0;
      end else begin
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
         flash_q  <= flash_d;
         act_q    <= act_d;
         stall_q  <= stall_d;
         cnt_q    <= cnt_d;
         blank_q  <= blank_d;
         nib_q    <= nib_d;
      end
   end

   assign nib0     = nib_q[3:0];
   assign nib1     = nib_q[7:4];
   assign nib2     = nib_q[11:8];
   assign nib3     = nib_q[15:12];
   assign blank    = blank_q;
   assign byte_cnt = cnt_q;
   assign activity = act_q;
   assign stall    = stall_q;

endmodule
